wb_splitter: RTL

- Single-master to two-slave pipelined Wishbone (B4 pipelined, with stall) address decoder and splitter.
- It is the slave-side counterpart to the bus arbiter: it fans one master bus out to slave A and slave B by address.
- It tracks outstanding requests so responses are never mis-routed, and it generates bus errors for unmapped addresses.
- It sits between the CPU bus (or arbiter output) and peripheral/memory slaves.

---
 rtl/wb_splitter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/wb_splitter.sv
// Pipelined Wishbone splitter: one master to two slaves by address decode.
// Outstanding requests are counted so responses are routed only from the owning slave.
module wb_splitter #(
    parameter int unsigned     AW     = 19,
    parameter int unsigned     DW     = 32,
    parameter logic [AW-1:0]   A_BASE = 19'h00000,
    parameter logic [AW-1:0]   A_MASK = 19'h40000,
    parameter logic [AW-1:0]   B_BASE = 19'h40000,
    parameter logic [AW-1:0]   B_MASK = 19'h40000,
    parameter int unsigned     LGOUT  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [AW-1:0]     i_wb_adr,
    input  logic [DW-1:0]     i_wb_data,
    input  logic [DW/8-1:0]   i_wb_sel,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [DW-1:0]     o_wb_idata,
    output logic              o_a_cyc,
    output logic              o_a_stb,
    input  logic              i_a_stall,
    input  logic              i_a_ack,
    input  logic              i_a_err,
    input  logic [DW-1:0]     i_a_data,
    output logic              o_b_cyc,
    output logic              o_b_stb,
    input  logic              i_b_stall,
    input  logic              i_b_ack,
    input  logic              i_b_err,
    input  logic [DW-1:0]     i_b_data,
    output logic              o_s_we,
    output logic [AW-1:0]     o_s_adr,
    output logic [DW-1:0]     o_s_data,
    output logic [DW/8-1:0]   o_s_sel
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_A, OWN_B, OWN_ERR} owner_t;
    typedef enum logic [1:0] {TGT_NONE, TGT_A, TGT_B} target_t;

    owner_t           owner;
    owner_t           next_owner;
    target_t          target;
    logic [LGOUT-1:0] count;
    logic             abort;
    logic             err_q;

    logic req, busy, full, same, blocked, slave_stall, stall, accept;
    logic live, owner_ack, owner_err, a_stb, b_stb;

    always_comb begin
        target = TGT_NONE;
        if ((i_wb_adr & A_MASK) == A_BASE)
            target = TGT_A;
        else if ((i_wb_adr & B_MASK) == B_BASE)
            target = TGT_B;

        next_owner = OWN_ERR;
        if (target == TGT_A)
            next_owner = OWN_A;
        else if (target == TGT_B)
            next_owner = OWN_B;

        req  = i_wb_cyc && i_wb_stb;
        busy = (count != '0);
        full = (count == '1);
        // An unmapped target never matches an owner, so this also holds off NONE while busy
        same    = (target == TGT_A && owner == OWN_A) || (target == TGT_B && owner == OWN_B);
        blocked = abort || full || (busy && !same);

        slave_stall = (target == TGT_A && i_a_stall) || (target == TGT_B && i_b_stall);
        stall       = blocked || slave_stall;
        accept      = req && !stall;

        a_stb = req && (target == TGT_A) && !blocked;
        b_stb = req && (target == TGT_B) && !blocked;

        live      = i_wb_cyc && !abort && busy;
        owner_ack = live && ((owner == OWN_A && i_a_ack) || (owner == OWN_B && i_b_ack));
        owner_err = live && ((owner == OWN_A && i_a_err) || (owner == OWN_B && i_b_err));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_wb_cyc) begin
            owner <= OWN_IDLE;
            count <= '0;
            abort <= 1'b0;
            err_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            // The error-pulse cycle of an unmapped access is followed by abort
            if (!abort && owner == OWN_ERR && busy) begin
                abort <= 1'b1;
                count <= '0;
            end else if (owner_err) begin
                abort <= 1'b1;
                count <= '0;
            end else if (!abort) begin
                if (accept && !owner_ack)
                    count <= count + 1'b1;
                else if (!accept && owner_ack)
                    count <= count - 1'b1;
                if (accept) begin
                    owner <= next_owner;
                    err_q <= (target == TGT_NONE);
                end
            end
        end
    end

    assign o_wb_stall = stall;
    assign o_wb_ack   = owner_ack;
    assign o_wb_err   = i_wb_cyc && (err_q || owner_err);
    assign o_wb_idata = (owner == OWN_B) ? i_b_data : i_a_data;

    assign o_a_stb = a_stb;
    assign o_b_stb = b_stb;
    assign o_a_cyc = i_wb_cyc && !abort && ((owner == OWN_A && busy) || a_stb);
    assign o_b_cyc = i_wb_cyc && !abort && ((owner == OWN_B && busy) || b_stb);

    assign o_s_we   = i_wb_we;
    assign o_s_adr  = i_wb_adr;
    assign o_s_data = i_wb_data;
    assign o_s_sel  = i_wb_sel;

endmodule
